// File: rtl/comparator_sweep_checker.sv
// comparator_sweep_checker: exhaustive stimulus source and response checker for
// a combinational WIDTH-bit magnitude comparator with eq/lt/gt outputs.
// Each operand pair is driven, allowed SETTLE cycles to propagate, then checked.
// Optional build macro: COMPARATOR_SWEEP_STOP_ON_FAIL_EN (end sweep at first mismatch).
module comparator_sweep_checker #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic             eq_in,
  input  logic             lt_in,
  input  logic             gt_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  localparam int unsigned SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [SCNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [WIDTH-1:0]  fa_q, fa_d;
  logic [WIDTH-1:0]  fb_q, fb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic [2:0]        exp_c;
  logic [2:0]        resp_c;
  logic              mismatch_c;
  logic              last_c;
  logic              stop_c;

  // Expected flags are one-hot, so any multi-high or all-low response mismatches.
  assign exp_c      = {a_q == b_q, a_q < b_q, a_q > b_q};
  assign resp_c     = {eq_in, lt_in, gt_in};
  assign mismatch_c = (resp_c != exp_c);
  assign last_c     = (&a_q) && (&b_q);

`ifdef COMPARATOR_SWEEP_STOP_ON_FAIL_EN
  assign stop_c = mismatch_c;
`else
  assign stop_c = 1'b0;
`endif

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    fa_d    = fa_q;
    fb_d    = fb_q;

    case (state_q)
      S_IDLE: begin
        a_d   = '0;
        b_d   = '0;
        err_d = '0;
        fa_d  = '0;
        fb_d  = '0;
        if (start) begin
          state_d = S_DRIVE;
        end
      end

      S_DRIVE: begin
        cnt_d   = SCNT_W'(SETTLE - 1);
        state_d = S_SETTLE;
      end

      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = SCNT_W'(cnt_q - 1'b1);
        end
      end

      S_CHECK: begin
        if (mismatch_c) begin
          if (err_q != {CNT_W{1'b1}}) begin
            err_d = CNT_W'(err_q + 1'b1);
          end
          if (err_q == '0) begin
            fa_d = a_q;
            fb_d = b_q;
          end
        end
        if (stop_c || last_c) begin
          state_d = S_DONE;
        end else begin
          b_d = WIDTH'(b_q + 1'b1);
          if (&b_q) begin
            a_d = WIDTH'(a_q + 1'b1);
          end
          state_d = S_DRIVE;
        end
      end

      S_DONE: begin
        if (start) begin
          a_d     = '0;
          b_d     = '0;
          err_d   = '0;
          fa_d    = '0;
          fb_d    = '0;
          state_d = S_DRIVE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_DRIVE) || (state_d == S_SETTLE) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_d == '0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign err_count = err_q;
  assign fail_a    = fa_q;
  assign fail_b    = fb_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_comparator_sweep_checker.sv
// Scoreboard bench: two checkers (SETTLE=1/CNT_W=16 and SETTLE=3/CNT_W=3) sweep a
// table-driven comparator model; a reference model predicts each sweep's result.
module tb_comparator_sweep_checker;

  typedef struct {
    int    err;
    int    fa;
    int    fb;
    int    fin_a;
    int    fin_b;
    int    dur;
    longint t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start;

  logic [3:0]  a1, b1, fa1, fb1;
  logic        eq1, lt1, gt1, busy1, done1, pass1;
  logic [15:0] err1;

  logic [3:0]  a2, b2, fa2, fb2;
  logic        eq2, lt2, gt2, busy2, done2, pass2;
  logic [2:0]  err2;

  logic [2:0]  resp_tbl [256];
  logic [2:0]  dly2 [4];

  exp_t q1[$];
  exp_t q2[$];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  comparator_sweep_checker #(.WIDTH(4), .SETTLE(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .start(start), .a_out(a1), .b_out(b1),
    .eq_in(eq1), .lt_in(lt1), .gt_in(gt1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .fail_a(fa1), .fail_b(fb1)
  );

  comparator_sweep_checker #(.WIDTH(4), .SETTLE(3), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .start(start), .a_out(a2), .b_out(b2),
    .eq_in(eq2), .lt_in(lt2), .gt_in(gt2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2), .fail_a(fa2), .fail_b(fb2)
  );

  // Comparator under test: zero-delay for dut1, SETTLE+1 cycles of propagation for dut2.
  assign {eq1, lt1, gt1} = resp_tbl[{a1, b1}];
  assign {eq2, lt2, gt2} = dly2[3];

  always @(posedge clk) begin
    dly2[0] <= resp_tbl[{a2, b2}];
    for (int i = 1; i < 4; i++) dly2[i] <= dly2[i-1];
  end

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Fill the comparator response table: 0 correct, 1 lt/gt swapped, 2 eq stuck 0, 3 random faults.
  task automatic build(input int mode);
    for (int i = 0; i < 256; i++) begin
      int a;
      int b;
      logic [2:0] e;
      a = i / 16;
      b = i % 16;
      e = {a == b, a < b, a > b};
      case (mode)
        1: resp_tbl[i] = {e[2], e[0], e[1]};
        2: resp_tbl[i] = {1'b0, e[1], e[0]};
        3: resp_tbl[i] = ($urandom_range(15, 0) == 0) ? (e ^ 3'($urandom_range(7, 1))) : e;
        default: resp_tbl[i] = e;
      endcase
    end
  endtask

  // Reference model: walk pairs in sweep order and apply the checking rules.
  function automatic exp_t model(input int settle, input int cnt_w);
    exp_t r;
    r.err = 0; r.fa = 0; r.fb = 0; r.fin_a = 15; r.fin_b = 15;
    r.dur = 256 * (settle + 2);
    r.t0  = 0;
    for (int i = 0; i < 256; i++) begin
      int a;
      int b;
      logic [2:0] e;
      a = i / 16;
      b = i % 16;
      e = {a == b, a < b, a > b};
      if (resp_tbl[i] != e) begin
        if (r.err == 0) begin
          r.fa = a;
          r.fb = b;
        end
        r.err++;
`ifdef COMPARATOR_SWEEP_STOP_ON_FAIL_EN
        r.fin_a = a;
        r.fin_b = b;
        r.dur   = (i + 1) * (settle + 2);
        break;
`endif
      end
    end
    if (r.err > (1 << cnt_w) - 1) r.err = (1 << cnt_w) - 1;
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy1), 0);
    chk({tag, "_done"}, int'(done1), 0);
    chk({tag, "_pass"}, int'(pass1), 0);
    chk({tag, "_ab"}, int'({a1, b1}), 0);
    chk({tag, "_err"}, int'(err1), 0);
    chk({tag, "_fail"}, int'({fa1, fb1}), 0);
    chk({tag, "_busy2"}, int'(busy2), 0);
    chk({tag, "_err2"}, int'(err2), 0);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!(done1 && done2) && k < 1300) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_timeout"}, int'(done1 && done2), 1);
  endtask

  task automatic run_sweep(input int mode, input bit poke_busy);
    exp_t e1;
    exp_t e2;
    build(mode);
    e1 = model(1, 16);
    e2 = model(3, 3);
    @(negedge clk);
    start = 1'b1;
    e1.t0 = $time + 5;
    e2.t0 = $time + 5;
    q1.push_back(e1);
    q2.push_back(e2);
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", int'(busy1), 1);
    chk("start_done", int'(done1), 0);
    chk("start_clear", int'({a1, b1, fa1, fb1}), 0);
    chk("start_err", int'(err1), 0);
    if (poke_busy) begin
      repeat (50) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done("sweep");
    repeat (3) @(negedge clk);
  endtask

  // Monitor for dut1: result checks on done rising, plus sweep-order checks.
  always @(negedge clk) begin : mon1
    static logic       pd = 1'b0;
    static logic       pb = 1'b0;
    static logic [7:0] pab = 8'd0;
    exp_t e;
    if (busy1 && pb && ({a1, b1} != pab)) begin
      chk("order", int'({a1, b1}), int'(8'(pab + 8'd1)));
    end
    if (done1 && !pd) begin
      if (q1.size() == 0) begin
        chk("unexpected_done1", 1, 0);
      end else begin
        e = q1.pop_front();
        chk("dur1", int'(($time - 5 - e.t0) / 10), e.dur);
        chk("err1", int'(err1), e.err);
        chk("pass1", int'(pass1), int'(e.err == 0));
        chk("fail_a1", int'(fa1), e.fa);
        chk("fail_b1", int'(fb1), e.fb);
        chk("final_a1", int'(a1), e.fin_a);
        chk("final_b1", int'(b1), e.fin_b);
        chk("busy_in_done1", int'(busy1), 0);
      end
    end
    pd  = done1;
    pb  = busy1;
    pab = {a1, b1};
  end

  // Monitor for dut2: longer settle and saturating 3-bit counter.
  always @(negedge clk) begin : mon2
    static logic pd = 1'b0;
    exp_t e;
    if (done2 && !pd) begin
      if (q2.size() == 0) begin
        chk("unexpected_done2", 1, 0);
      end else begin
        e = q2.pop_front();
        chk("dur2", int'(($time - 5 - e.t0) / 10), e.dur);
        chk("err2_sat", int'(err2), e.err);
        chk("pass2", int'(pass2), int'(e.err == 0));
        chk("fail_a2", int'(fa2), e.fa);
        chk("fail_b2", int'(fb2), e.fb);
      end
    end
    pd = done2;
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    build(0);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("idle");

    run_sweep(0, 1'b0);
    run_sweep(1, 1'b0);
    run_sweep(2, 1'b1);

    // Abandon a sweep mid-way with reset, then sweep again from (0,0).
    build(0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("midrst");

    run_sweep(3, 1'b0);
    run_sweep(3, 1'b1);
    run_sweep(0, 1'b0);

    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/comparator_sweep_checker.md
Name: comparator_sweep_checker

Overview:
- Synchronous stimulus source and response checker for any combinational WIDTH-bit magnitude comparator with eq/lt/gt outputs.
- Drives every (a,b) operand pair to the comparator under test, waits a settle interval, then samples eq/lt/gt against internally computed expected flags.
- Counts mismatches and reports pass/fail.
- Used for on-board and in-simulation self-test of comparator blocks; replaces hand-written directed stimulus.

Parameters:
- WIDTH, 4, operand width in bits; sweep covers 2^(2*WIDTH) pairs.
- SETTLE, 1, cycles between driving an operand pair and sampling responses (min 1).
- CNT_W, 16, width of the error counter.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous reset, active-high
- start  input  1  one-cycle pulse; starts a sweep when idle
- a_out  output  WIDTH  operand A to the comparator under test
- b_out  output  WIDTH  operand B to the comparator under test
- eq_in  input  1  comparator response, A==B
- lt_in  input  1  comparator response, A<B
- gt_in  input  1  comparator response, A>B
- busy  output  1  sweep in progress
- done  output  1  sweep finished; held until next start or rst
- pass  output  1  valid when done; 1 iff err_count==0
- err_count  output  CNT_W  number of mismatching pairs, saturating
- fail_a  output  WIDTH  A of the first mismatching pair
- fail_b  output  WIDTH  B of the first mismatching pair

Behaviour:
- Clock: one clock, clk.
- Reset: synchronous, active-high, on rst. All outputs reset to 0; state returns to IDLE.
- rst mid-sweep: abandons the sweep; the next cycle is IDLE with all outputs 0.
- State IDLE:
  - start=1 moves to DRIVE.
  - a_out, b_out, err_count, fail_a and fail_b clear to 0.
  - done and pass clear to 0.
- State DRIVE:
  - Holds the current a_out/b_out.
  - Loads the settle counter with SETTLE-1 and moves to SETTLE.
- State SETTLE: decrements the counter; moves to CHECK when it reads 0.
- Latency: exactly SETTLE+1 cycles from a new operand pair appearing to it being sampled.
- State CHECK:
  - Expected flags are exp_eq=(a==b), exp_lt=(a<b), exp_gt=(a>b), with a and b unsigned.
  - Mismatch = any of eq_in/lt_in/gt_in differs from its expected flag.
  - A response with more than one flag high is a mismatch.
  - A response with all flags low is a mismatch.
  - On mismatch, err_count increments, saturating at all-ones.
  - On the first mismatch only (err_count was 0), fail_a/fail_b capture the pair.
- Operand advance, taken from CHECK:
  - b_out increments.
  - When b_out wraps from all-ones to 0, a_out increments.
  - When a_out and b_out are both all-ones, the next state is DONE instead of DRIVE.
- Sweep order: A outer, B inner, ascending from (0,0) to (2^W-1, 2^W-1).
- State DONE:
  - busy=0, done=1, pass=(err_count==0).
  - a_out/b_out hold their last value.
  - start=1 in DONE clears done, pass, err_count, fail_a, fail_b, a_out and b_out in the same cycle and moves to DRIVE.
- busy: 1 in DRIVE, SETTLE and CHECK; 0 in IDLE and DONE.
- start while busy is ignored.
- Sweep duration: 2^(2W)*(SETTLE+2) cycles from the start pulse to done.

Optional Feature:
- Macro: COMPARATOR_SWEEP_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK moves directly to DONE.
  - err_count=1, pass=0.
  - fail_a/fail_b hold the failing pair.
  - a_out/b_out are frozen at the failing pair.
- Undefined: the sweep always runs to completion as described in Behaviour.

Test Plan:
- Correct 4-bit comparator model, SETTLE=1, pulse start: done rises after 256*3 cycles; pass=1, err_count=0, fail_a=fail_b=0.
- Model with lt/gt swapped: done with pass=0, err_count=240, fail_a=0, fail_b=1.
- Model with eq stuck at 0: err_count=16, fail_a=0, fail_b=0.
- rst asserted at cycle 100 of a sweep: next cycle busy=0, done=0, a_out=b_out=0, err_count=0. A new start then sweeps from (0,0).
- start pulsed while busy: no restart, and the sweep ends at the same cycle count. start in DONE: counters clear and a new sweep begins.
- With COMPARATOR_SWEEP_STOP_ON_FAIL_EN defined and the eq-stuck-0 model: done asserts right after the (0,0) check; err_count=1, a_out=b_out=0.
